// File: rtl/display_pkg.sv
`default_nettype none
// =============================================================================
//  Package     : display_pkg
//  Description : Shared encodings for the MM:SS BCD stopwatch.
//  Revision    : 1.0 - initial release
// =============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] DIG_MAX_9 = 4'd9;
    localparam logic [3:0] DIG_MAX_5 = 4'd5;

    localparam logic [1:0] SEL_SEC_ONES = 2'd0;
    localparam logic [1:0] SEL_SEC_TENS = 2'd1;
    localparam logic [1:0] SEL_MIN_ONES = 2'd2;
    localparam logic [1:0] SEL_MIN_TENS = 2'd3;

    // Anything at or above the limit folds to 0, so a digit can never exceed it.
    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// =============================================================================
//  Module      : key_debounce
//  Description : Active-low raw key -> 1-cycle press pulse. 2-FF synchroniser,
//                stable-level filter when KEY_DEBOUNCE_EN is defined, falling-edge detect.
//  Revision    : 1.0 - initial release
// =============================================================================
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    if (DEB_CYCLES == 0) begin : g_deb_range
        $error("key_debounce: DEB_CYCLES must be at least 1");
    end

    // Idle key level is high, so reset to released to avoid a spurious press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          filt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level_d & ~level;

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// =============================================================================
//  Module      : bcd_time_counter
//  Description : MM:SS stopwatch with start/stop and clear keys, packed BCD and
//                muxed digit outputs. Key filtering enabled by KEY_DEBOUNCE_EN.
//  Revision    : 1.0 - initial release
// =============================================================================
module bcd_time_counter
    import display_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        key_start_n,
    input  logic        key_clear_n,
    input  logic [1:0]  digit_sel,
    output logic [3:0]  data,
    output logic [15:0] bcd_all,
    output logic        running,
    output logic        wrap_pulse
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          start_p;
    logic          clear_p;
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          at_max;
    logic [3:0]    sec_ones;
    logic [3:0]    sec_tens;
    logic [3:0]    min_ones;
    logic [3:0]    min_tens;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (key_start_n),
        .pulse (start_p)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_clear (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (key_clear_n),
        .pulse (clear_p)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear has priority over start/stop.
    always_comb begin
        state_nxt = state;
        if (clear_p) begin
            state_nxt = ST_IDLE;
        end else if (start_p) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    assign tick   = (state == ST_RUN) && (presc == PRESC_LAST);
    assign at_max = (sec_ones == DIG_MAX_9) && (sec_tens == DIG_MAX_5) &&
                    (min_ones == DIG_MAX_9) && (min_tens == DIG_MAX_5);

    // PAUSE holds the partial second so a resume continues it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (clear_p) begin
            presc <= '0;
        end else begin
            case (state)
                ST_RUN:   presc <= tick ? '0 : presc + PW'(1);
                ST_PAUSE: presc <= presc;
                default:  presc <= '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else if (clear_p) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
        end else if (tick) begin
            sec_ones <= bcd_next(sec_ones, DIG_MAX_9);
            if (sec_ones == DIG_MAX_9) begin
                sec_tens <= bcd_next(sec_tens, DIG_MAX_5);
                if (sec_tens == DIG_MAX_5) begin
                    min_ones <= bcd_next(min_ones, DIG_MAX_9);
                    if (min_ones == DIG_MAX_9) begin
                        min_tens <= bcd_next(min_tens, DIG_MAX_5);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= tick && at_max && !clear_p;
        end
    end

    assign bcd_all = {min_tens, min_ones, sec_tens, sec_ones};
    assign running = (state == ST_RUN);

    always_comb begin
        data = sec_ones;
        case (digit_sel)
            SEL_SEC_ONES: data = sec_ones;
            SEL_SEC_TENS: data = sec_tens;
            SEL_MIN_ONES: data = min_ones;
            SEL_MIN_TENS: data = min_tens;
            default:      data = sec_ones;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// =============================================================================
//  Module      : tb_bcd_time_counter
//  Description : Self-checking bench for bcd_time_counter (TICK_DIV=4, DEB_CYCLES=8).
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_bcd_time_counter;

    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 8;
`ifdef KEY_DEBOUNCE_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int KEY_LAT = FILT ? 3 + DEB_CYCLES : 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        key_start_n;
    logic        key_clear_n;
    logic [1:0]  digit_sel;
    logic [3:0]  data;
    logic [15:0] bcd_all;
    logic        running;
    logic        wrap_pulse;

    bcd_time_counter #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .key_start_n (key_start_n),
        .key_clear_n (key_clear_n),
        .digit_sel   (digit_sel),
        .data        (data),
        .bcd_all     (bcd_all),
        .running     (running),
        .wrap_pulse  (wrap_pulse)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed time kept as whole seconds, state as 0=idle 1=run 2=pause.
    int          m_secs;
    int          m_presc;
    int          m_state;
    bit          m_wrap;
    int          wrap_count;
    logic [15:0] hist_s;
    logic [15:0] hist_c;
    bit          f1_s, f2_s, f1_c, f2_c;
    int          hold_s, hold_c;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_bcd();
        int m;
        int s;
        m = m_secs / 60;
        s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int elapsed();
        return m_secs * TICK_DIV + m_presc;
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_presc = 0;
        m_state = 0;
        m_wrap  = 0;
        hist_s  = '1;
        hist_c  = '1;
        f1_s = 1; f2_s = 1; f1_c = 1; f2_c = 1;
    endtask

    // h[j] is the raw key level seen j edges ago. A press takes effect 3 edges
    // after the raw fall, plus DEB_CYCLES stable samples when filtered.
    task automatic key_event(input logic [15:0] h, inout bit f1, inout bit f2, output bit p);
        bit flip;
        if (!FILT) begin
            p = h[3] && !h[2];
        end else begin
            p = f2 && !f1;
            flip = 1;
            for (int j = 2; j <= DEB_CYCLES + 1; j++) begin
                if (h[j] == f1) flip = 0;
            end
            f2 = f1;
            if (flip) f1 = !f1;
        end
    endtask

    task automatic model_edge();
        bit sp, cp, tk;
        hist_s = {hist_s[14:0], key_start_n};
        hist_c = {hist_c[14:0], key_clear_n};
        key_event(hist_s, f1_s, f2_s, sp);
        key_event(hist_c, f1_c, f2_c, cp);
        tk     = (m_state == 1) && (m_presc == TICK_DIV - 1);
        m_wrap = 0;
        if (cp) begin
            m_state = 0;
            m_secs  = 0;
            m_presc = 0;
        end else begin
            if (tk) begin
                m_wrap = (m_secs == 3599);
                m_secs = (m_secs + 1) % 3600;
            end
            if (m_state == 1)      m_presc = (m_presc + 1) % TICK_DIV;
            else if (m_state == 0) m_presc = 0;
            if (sp) m_state = (m_state == 1) ? 2 : 1;
        end
        if (m_wrap) wrap_count++;
    endtask

    task automatic step();
        logic [15:0] b;
        @(posedge CLK);
        model_edge();
        #1;
        b = m_bcd();
        check("bcd_all", bcd_all, b);
        check("running", running, (m_state == 1));
        check("wrap_pulse", wrap_pulse, m_wrap);
        check("data", data, b[int'(digit_sel) * 4 +: 4]);
        if (hold_s > 0) begin
            hold_s--;
            if (hold_s == 0) key_start_n = 1'b1;
        end
        if (hold_c > 0) begin
            hold_c--;
            if (hold_c == 0) key_clear_n = 1'b1;
        end
    endtask

    task automatic press_async(input bit s, input bit c, input int len);
        if (s) begin key_start_n = 1'b0; hold_s = len; end
        if (c) begin key_clear_n = 1'b0; hold_c = len; end
    endtask

    task automatic press(input bit s, input bit c, input int len);
        press_async(s, c, len);
        repeat (len) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #1;
        check("rst_bcd_all", bcd_all, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_wrap", wrap_pulse, 1'b0);
        check("rst_data", data, 4'h0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic run_until(input int target, input int bound);
        int n;
        n = 0;
        while (elapsed() != target && n < bound) begin
            step();
            n++;
        end
        check("run_until_reached", elapsed(), target);
    endtask

    task automatic wait_state(input int st, input int bound);
        int n;
        n = 0;
        while (m_state != st && n < bound) begin
            step();
            n++;
        end
        check("wait_state_reached", m_state, st);
    endtask

    initial begin
        int n;
        bit exp_run;

        vecs[0] = '{sel: 2'd0, exp_data: 4'd4};
        vecs[1] = '{sel: 2'd1, exp_data: 4'd3};
        vecs[2] = '{sel: 2'd2, exp_data: 4'd2};
        vecs[3] = '{sel: 2'd3, exp_data: 4'd1};

        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        digit_sel   = 2'd0;
        hold_s      = 0;
        hold_c      = 0;
        wrap_count  = 0;

        // 1: reset, then idle for 100 cycles
        do_reset();
        repeat (100) step();
        check("idle_bcd", bcd_all, 16'h0000);

        // 2: start, 10 ticks
        press_async(1, 0, 12);
        wait_state(1, 40);
        repeat (40) step();
        check("ten_ticks_bcd", bcd_all, 16'h0010);
        check("ten_ticks_running", running, 1'b1);
        digit_sel = 2'd1; #1;
        check("sel1_data", data, 4'd1);
        digit_sel = 2'd0; #1;
        check("sel0_data", data, 4'd0);

        // Pause at 12:34 with the prescaler at 2, then read every digit.
        run_until(754 * TICK_DIV + 2 - KEY_LAT, 5000);
        press(1, 0, 12);
        check("paused_running", running, 1'b0);
        check("paused_bcd", bcd_all, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            digit_sel = vecs[i].sel;
            #1;
            check("digit_table", data, vecs[i].exp_data);
        end
        digit_sel = 2'd0;

        // 4: frozen during pause, resume finishes the partial second
        repeat (50) step();
        check("frozen_bcd", bcd_all, 16'h1234);
        press_async(1, 0, 12);
        wait_state(1, 40);
        n = 0;
        while (bcd_all == 16'h1234 && n < 20) begin
            step();
            n++;
        end
        check("resume_tick_latency", n, 2);
        check("resume_bcd", bcd_all, 16'h1235);

        // 3: rollover
        run_until(3598 * TICK_DIV, 20000);
        check("preload_bcd", bcd_all, 16'h5958);
        wrap_count = 0;
        repeat (2 * TICK_DIV) step();
        check("wrap_bcd", bcd_all, 16'h0000);
        check("wrap_count", wrap_count, 1);
        repeat (TICK_DIV) step();
        check("after_wrap_bcd", bcd_all, 16'h0001);
        check("after_wrap_running", running, 1'b1);

        // 5: simultaneous start and clear in RUN, then async reset mid-count
        press(1, 1, 12);
        repeat (5) step();
        check("clear_wins_running", running, 1'b0);
        check("clear_wins_bcd", bcd_all, 16'h0000);
        press(1, 0, 12);
        repeat (30) step();
        check("pre_rst_running", running, 1'b1);
        #2;
        do_reset();

        // 6: short glitch vs full press
        press(1, 0, 5);
        repeat (20) step();
        exp_run = FILT ? 1'b0 : 1'b1;
        check("glitch_running", running, exp_run);
        press(1, 0, 12);
        repeat (20) step();
        exp_run = FILT ? 1'b1 : 1'b0;
        check("press_running", running, exp_run);

        // Randomised key activity against the model.
        for (int it = 0; it < 150; it++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 20);
            digit_sel = 2'($urandom_range(0, 3));
            if (kind <= 5)      press(1, 0, len);
            else if (kind <= 7) press(0, 1, len);
            else if (kind == 8) press(1, 1, len);
            repeat ($urandom_range(0, 40)) step();
            if ($urandom_range(0, 49) == 0) begin
                #2;
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
